// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: geometry, FSM states
// and the instruction value presented to fetch while the RAM is being loaded.
package inst_mem_loader_pkg;

    localparam int ADDR_W         = 6;
    localparam int DEPTH          = 64;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Little-endian word assembly: lane 0 lands in the least significant byte.
    function automatic logic [31:0] pack_word(
        input logic [7:0] b3,
        input logic [7:0] b2,
        input logic [7:0] b1,
        input logic [7:0] b0
    );
        return {b3, b2, b1, b0};
    endfunction

endpackage

// File: rtl/inst_mem_loader_ram.sv
// Instruction RAM: one synchronous write port for the loader and one
// combinational read port for fetch. Contents are intentionally not reset.
module inst_ram #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [DEPTH];

    // Store one assembled word on the edge that accepts its last byte.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_mem_loader.sv
// Byte-stream loader for the instruction RAM. Packs host bytes four at a time
// into little-endian words, writes them sequentially from address 0, and
// serves fetch through a ROM-compatible ce/addr/inst port that reads as NOP
// while a load is in progress.
module inst_mem_loader #(
    parameter int ADDR_W = inst_mem_loader_pkg::ADDR_W,
    parameter int DEPTH  = inst_mem_loader_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_cnt,
    input  logic              ce,
    input  logic [ADDR_W-1:0] addr,
    output logic [31:0]       inst
);

    import inst_mem_loader_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0]      LAST_LANE = 2'(BYTES_PER_WORD - 1);

    state_e            state_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [1:0]        byte_idx_q;
    logic [7:0]        lane0_q;
    logic [7:0]        lane1_q;
    logic [7:0]        lane2_q;
    logic [ADDR_W:0]   word_cnt_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;

    logic [ADDR_W:0]   len_d;
    logic [ADDR_W:0]   word_cnt_d;
    logic              accept_s;
    logic              we_s;
    logic [31:0]       wdata_s;
    logic [31:0]       rdata_s;

    // Clamp the requested length, and qualify byte acceptance and RAM writes;
    // a restart on the same edge wins over the last byte of a word.
    always_comb begin
        len_d      = len_words;
        word_cnt_d = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
        accept_s   = byte_valid & ready_q;
        we_s       = 1'b0;
        wdata_s    = pack_word(byte_data, lane2_q, lane1_q, lane0_q);
        if (len_words > DEPTH_W) begin
            len_d = DEPTH_W;
        end else begin
            len_d = len_words;
        end
        if (accept_s && !start && (byte_idx_q == LAST_LANE)) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    // Loader FSM with byte assembler, address/count registers and registered status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            len_q      <= {(ADDR_W + 1){1'b0}};
            wr_addr_q  <= {ADDR_W{1'b0}};
            byte_idx_q <= 2'd0;
            lane0_q    <= 8'h00;
            lane1_q    <= 8'h00;
            lane2_q    <= 8'h00;
            word_cnt_q <= {(ADDR_W + 1){1'b0}};
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (start) begin
            // Start (or restart) from any state; a partial word is discarded.
            len_q      <= len_d;
            wr_addr_q  <= {ADDR_W{1'b0}};
            byte_idx_q <= 2'd0;
            word_cnt_q <= {(ADDR_W + 1){1'b0}};
            if (len_d != {(ADDR_W + 1){1'b0}}) begin
                state_q <= ST_LOAD;
                ready_q <= 1'b1;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end else begin
                state_q <= ST_DONE;
                ready_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= state_q;
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        case (byte_idx_q)
                            2'd0:    lane0_q <= byte_data;
                            2'd1:    lane1_q <= byte_data;
                            2'd2:    lane2_q <= byte_data;
                            default: lane2_q <= lane2_q;
                        endcase
                        if (byte_idx_q == LAST_LANE) begin
                            byte_idx_q <= 2'd0;
                            wr_addr_q  <= wr_addr_q + {{(ADDR_W - 1){1'b0}}, 1'b1};
                            word_cnt_q <= word_cnt_d;
                            if (word_cnt_d == len_q) begin
                                state_q <= ST_DONE;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    inst_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (wr_addr_q),
        .wdata (wdata_s),
        .raddr (addr),
        .rdata (rdata_s)
    );

    // Fetch port: RAM contents when enabled and not loading, NOP otherwise.
    always_comb begin
        inst = NOP_INST;
        if (ce && (state_q != ST_LOAD)) begin
            inst = rdata_s;
        end else begin
            inst = NOP_INST;
        end
    end

    assign byte_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: directed scenarios plus randomized loads, all
// checked every cycle against a transaction-level model (byte queue + word
// array), with literal expectations pinning the model on known streams.
module tb_inst_mem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [6:0]  len_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        busy;
    logic        done;
    logic [6:0]  word_cnt;
    logic        ce;
    logic [5:0]  addr;
    logic [31:0] inst;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    bit          m_loading;
    bit          m_done;
    int          m_len;
    int          m_cnt;
    int          m_wr;
    logic [7:0]  m_bytes [$];
    logic [31:0] m_mem   [64];
    bit          m_valid [64];

    bit chk_en    = 1'b0;
    bit fix_fetch = 1'b1;

    inst_mem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len_words  (len_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done),
        .word_cnt   (word_cnt),
        .ce         (ce),
        .addr       (addr),
        .inst       (inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading = 1'b0;
        m_done    = 1'b0;
        m_cnt     = 0;
        m_wr      = 0;
        m_len     = 0;
        m_bytes.delete();
    endtask

    // One clock edge of the loader, described as a transaction: start
    // (re)opens a load of min(len,64) words; bytes collect in a queue and
    // every fourth one commits a little-endian word.
    task automatic model_step(input logic s, input logic [6:0] l, input logic v, input logic [7:0] d);
        if (s) begin
            m_len = (int'(l) > 64) ? 64 : int'(l);
            m_cnt = 0;
            m_wr  = 0;
            m_bytes.delete();
            m_loading = (m_len != 0);
            m_done    = (m_len == 0);
        end else if (m_loading && v) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == 4) begin
                m_mem[m_wr]   = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                m_valid[m_wr] = 1'b1;
                m_wr++;
                m_cnt++;
                m_bytes.delete();
                if (m_cnt == m_len) begin
                    m_loading = 1'b0;
                    m_done    = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle(input logic s, input logic [6:0] l, input logic v, input logic [7:0] d);
        start      = s;
        len_words  = l;
        byte_valid = v;
        byte_data  = d;
        if (!fix_fetch) begin
            ce   = 1'($urandom_range(0, 1));
            addr = 6'($urandom_range(0, 63));
        end
        @(posedge clk);
        model_step(s, l, v, d);
        #1;
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("byte_ready", {31'd0, byte_ready}, {31'd0, m_loading});
            chk("busy",       {31'd0, busy},       {31'd0, m_loading});
            chk("done",       {31'd0, done},       {31'd0, m_done});
            chk("word_cnt",   {25'd0, word_cnt},   32'(m_cnt));
            if (ce && !m_loading) begin
                if (m_valid[addr]) begin
                    chk("inst_read", inst, m_mem[addr]);
                end
            end else begin
                chk("inst_nop", inst, 32'h0000_0000);
            end
        end
    end

    logic [7:0] basic_bytes [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    initial begin
        int guard;
        rst = 1'b0; start = 1'b0; len_words = 7'd0; byte_valid = 1'b0;
        byte_data = 8'h00; ce = 1'b0; addr = 6'd0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        model_reset();

        // Reset values.
        #12;
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_done",       {31'd0, done},       32'd0);
        chk("rst_word_cnt",   {25'd0, word_cnt},   32'd0);
        chk("rst_inst",       inst,                32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        chk_en = 1'b1;
        cycle(1'b0, 7'd0, 1'b1, 8'h55);   // ignored in IDLE

        // Basic load, fetch held on addr 0 to see NOPs during LOAD.
        ce = 1'b1; addr = 6'd0;
        cycle(1'b1, 7'd2, 1'b0, 8'h00);
        chk("load_ready_after_start", {31'd0, byte_ready}, 32'd1);
        chk("load_inst_blocked", inst, 32'h0000_0000);
        for (int i = 0; i < 8; i++) cycle(1'b0, 7'd0, 1'b1, basic_bytes[i]);
        chk("basic_done",     {31'd0, done},     32'd1);
        chk("basic_word_cnt", {25'd0, word_cnt}, 32'd2);
        addr = 6'd0; #1;
        chk("basic_mem0", inst, 32'h1234_5678);
        addr = 6'd1; #1;
        chk("basic_mem1", inst, 32'hDEAD_BEEF);
        cycle(1'b0, 7'd0, 1'b1, 8'hAA);   // ignored in DONE

        // Backpressure: bytes on alternate cycles.
        cycle(1'b1, 7'd2, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 7'd0, 1'b0, 8'hFF);
            cycle(1'b0, 7'd0, 1'b1, basic_bytes[i]);
            if (i == 3) chk("gap_cnt_after_4", {25'd0, word_cnt}, 32'd1);
        end
        addr = 6'd1; #1;
        chk("gap_mem1", inst, 32'hDEAD_BEEF);

        // Abort: restart coincides with the 4th byte, which is dropped.
        cycle(1'b1, 7'd1, 1'b0, 8'h00);
        cycle(1'b0, 7'd0, 1'b1, 8'h11);
        cycle(1'b0, 7'd0, 1'b1, 8'h22);
        cycle(1'b0, 7'd0, 1'b1, 8'h33);
        cycle(1'b1, 7'd1, 1'b1, 8'h44);
        chk("abort_cnt", {25'd0, word_cnt}, 32'd0);
        cycle(1'b0, 7'd0, 1'b1, 8'h04);
        cycle(1'b0, 7'd0, 1'b1, 8'h03);
        cycle(1'b0, 7'd0, 1'b1, 8'h02);
        cycle(1'b0, 7'd0, 1'b1, 8'h01);
        addr = 6'd0; #1;
        chk("abort_mem0", inst, 32'h0102_0304);

        // Zero length goes straight to DONE.
        cycle(1'b1, 7'd0, 1'b0, 8'h00);
        chk("len0_done", {31'd0, done},       32'd1);
        chk("len0_busy", {31'd0, busy},       32'd0);

        // Clamp: 100 words requested, 64 loaded.
        cycle(1'b1, 7'd100, 1'b0, 8'h00);
        for (int k = 0; k < 256; k++) cycle(1'b0, 7'd0, 1'b1, 8'(k));
        chk("clamp_done", {31'd0, done},       32'd1);
        chk("clamp_cnt",  {25'd0, word_cnt},   32'd64);
        addr = 6'd63; #1;
        chk("clamp_mem63", inst, 32'hFFFE_FDFC);
        addr = 6'd0; #1;
        chk("clamp_mem0", inst, 32'h0302_0100);

        // Mid-load reset: partial word lost, written word kept.
        cycle(1'b1, 7'd3, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) cycle(1'b0, 7'd0, 1'b1, 8'hC0 + 8'(i));
        rst = 1'b0;
        model_reset();
        #1;
        chk("midrst_busy", {31'd0, busy},     32'd0);
        chk("midrst_cnt",  {25'd0, word_cnt}, 32'd0);
        addr = 6'd0; #1;
        chk("midrst_mem0", inst, 32'hC3C2_C1C0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Randomized loads with gaps, random fetch traffic and rare aborts.
        fix_fetch = 1'b0;
        for (int n = 0; n < 25; n++) begin
            logic [6:0] l;
            l = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(60, 127)) : 7'($urandom_range(0, 10));
            cycle(1'b1, l, 1'($urandom_range(0, 1)), 8'($urandom));
            guard = 0;
            while (m_loading && guard < 2000) begin
                if ($urandom_range(0, 150) == 0)
                    cycle(1'b1, 7'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), 8'($urandom));
                else
                    cycle(1'b0, 7'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom));
                guard++;
            end
            chk("rand_load_finished", {31'd0, done}, 32'd1);
            for (int j = 0; j < 4; j++) cycle(1'b0, 7'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Writer-side counterpart to instruction fetch. Receives a byte stream from a host/debug link, packs each 4 bytes little-endian into a 32-bit instruction, and writes it into a 64-entry instruction RAM. The same RAM serves the fetch side through a ROM-compatible read port (`ce`/`addr`/`inst`), so the PC register connects to this block exactly as it connects to the plain ROM.

## Interface

Parameters:
- `ADDR_W`, default 6: word address width; matches PC width.
- `DEPTH`, default 64: number of 32-bit words; equals 2**ADDR_W.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst`  in  1  Reset, asynchronous, active-low.
- `start`  in  1  One-cycle pulse. Begins a load and samples `len_words`.
- `len_words`  in  ADDR_W+1  Number of words to load. Sampled at `start`. Values above DEPTH are clamped to DEPTH.
- `byte_valid`  in  1  Host byte is present.
- `byte_data`  in  8  Host byte.
- `byte_ready`  out  1  Block accepts bytes. High only in LOAD.
- `busy`  out  1  High in LOAD.
- `done`  out  1  Sticky. High in DONE; cleared by `start`.
- `word_cnt`  out  ADDR_W+1  Words written since the last `start`.
- `ce`  in  1  Fetch read enable (from the PC register).
- `addr`  in  ADDR_W  Fetch word address.
- `inst`  out  32  Fetched instruction.

## Operation

- States are IDLE, LOAD and DONE. Reset enters IDLE.
- IDLE or DONE, with `start` asserted:
  - Sample `len_words` into `len_q` (clamped).
  - Clear `wr_addr`, `byte_idx` and `word_cnt`.
  - Go to LOAD if `len_q` is nonzero, otherwise go to DONE.
- LOAD:
  - `byte_ready` is 1. A byte is accepted when `byte_valid` and `byte_ready` are both high.
  - An accepted byte is stored in lane `byte_idx`: lane 0 goes to [7:0] and lane 3 goes to [31:24].
  - `byte_idx` wraps from 3 to 0.
- Fourth accepted byte of a word:
  - Write {byte_data, lane2, lane1, lane0} to `mem[wr_addr]` on that edge.
  - Increment `wr_addr` and `word_cnt`.
  - If the new `word_cnt` equals `len_q`, go to DONE on the same edge.
- `start` during LOAD aborts and restarts:
  - A partially assembled word is discarded.
  - Words already written are kept.
  - `len_words` is re-sampled.
  - `start` has priority over a simultaneous byte acceptance; that byte is dropped.
- `byte_valid` with `byte_ready` low (IDLE or DONE) is ignored. Nothing is written.
- Fetch read:
  - `inst` = `mem[addr]` when `ce` is 1 and the state is not LOAD.
  - `inst` = 32'h0 otherwise. Fetch sees NOPs while a load is in progress.
- Memory contents are not reset. The loader is the only writer.
- `word_cnt` never exceeds DEPTH. `wr_addr` does not wrap within one load, because of the clamp.

## Timing

- Reset values (asynchronous, immediate):
  - State is IDLE.
  - `byte_ready`, `busy` and `done` are 0.
  - `word_cnt` is 0.
  - `inst` is 0 unless `ce` is high with valid memory contents.
- Reset asserted mid-load returns to IDLE. The partial word is lost and written words remain.
- `start` to `byte_ready` high: 1 cycle (registered state).
- Byte acceptance rate: one per cycle. The minimum time to load N words is 4N cycles.
- The last byte's edge writes memory and sets `done` and state DONE together. `inst` reflects the new word combinationally in the following cycle.
- The read path is combinational with zero latency, identical to the ROM it replaces.
- `byte_ready` does not depend combinationally on `byte_valid`.

## Structure

- Shared package holds:
  - the state enum (IDLE, LOAD, DONE);
  - `ADDR_W`, `DEPTH`;
  - `NOP_INST` = 32'h0;
  - `BYTES_PER_WORD` = 4.
- Sub-module `inst_ram`: DEPTH x 32, one synchronous write port (`we`, `waddr`, `wdata`) and one asynchronous read port (`raddr`, `rdata`).
- Top level holds the FSM, the byte assembler (lanes 0-2 plus `byte_idx`), the address/count registers and the `inst` mux.

## Test plan

- Reset: hold `rst` low, then release. `byte_ready`, `busy` and `done` are 0, `word_cnt` is 0, and `inst` is 0 with `ce` low.
- Basic load: `start` with `len_words`=2, bytes 78 56 34 12 EF BE AD DE at one per cycle.
  - `done` rises on the edge of the 8th byte and `word_cnt` is 2.
  - `ce`=1, `addr`=0 returns 32'h12345678; `addr`=1 returns 32'hDEADBEEF.
- Backpressure gaps: the same stream with `byte_valid` low on alternate cycles. Same memory result. `word_cnt` increments only on the 4th and 8th accepted bytes.
- Fetch blocked during load: `ce`=1, `addr`=0 while in LOAD gives `inst`=0. After DONE the loaded value appears.
- Abort: `start` (len=1) and 3 bytes accepted, then `start` again (len=1) in the same cycle as a 4th byte.
  - No write occurs and the 4th byte is dropped.
  - The next bytes 04 03 02 01 give `mem[0]`=32'h01020304.
- Boundaries:
  - `len_words`=0 gives DONE one cycle after `start` with no writes.
  - `len_words`=100 clamps to 64: `done` after 256 bytes, `word_cnt`=64, and `addr`=63 holds the last word.
